// File: rtl/main_memory_responder.sv
// Memory-side responder: 128-bit line fills plus a write-through store buffer.
// Define MEM_STATS_EN to add fill/store counter outputs.
module main_memory_responder #(
    parameter int DEPTH_WORDS  = 1024,
    parameter int READ_LATENCY = 4,
    parameter int WBUF_DEPTH   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ireq_valid,
    input  logic [31:0]  ireq_addr,
    output logic         oreq_ready,
    output logic         oline_valid,
    output logic [127:0] oline_data,
    input  logic         iwr_valid,
    input  logic [31:0]  iram_addr_wdata,
    input  logic [31:0]  iram_data_wdata,
    output logic         owr_ready,
`ifdef MEM_STATS_EN
    output logic [31:0]  ofill_count,
    output logic [31:0]  ostore_count,
`endif
    output logic         obusy
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int PW = $clog2(WBUF_DEPTH);
    localparam int CW = PW + 1;
    localparam int LW = $clog2(READ_LATENCY);
    localparam logic [LW-1:0] LAT_INIT = LW'(READ_LATENCY - 2);
    localparam logic [CW-1:0] FULL     = CW'(WBUF_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_READ_WAIT,
        S_RESP
    } state_e;

    logic [31:0]   mem_q [DEPTH_WORDS];
    logic [AW-1:0] wb_addr_q [WBUF_DEPTH];
    logic [31:0]   wb_data_q [WBUF_DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    state_e        state_q, state_d;
    logic [LW-1:0] lat_q, lat_d;
    logic [AW-3:0] line_idx_q, line_idx_d;
    logic [127:0]  line_q, line_d;
    logic          oline_valid_q, oline_valid_d;
    logic          oreq_ready_q, oreq_ready_d;
    logic          obusy_q, obusy_d;

    logic push;
    logic pop;
    logic mem_we;
    logic fill_acc;
    logic unused_addr_bits;

    assign unused_addr_bits = ^{ireq_addr[31:AW+2], ireq_addr[3:0],
                                iram_addr_wdata[31:AW+2], iram_addr_wdata[1:0]};

    assign owr_ready = (count_q != FULL);
    assign push      = iwr_valid && owr_ready;
    assign pop       = (count_q != '0) &&
                       ((state_q == S_IDLE) || (state_q == S_DRAIN));
    assign mem_we    = pop && !rst;
    assign fill_acc  = ireq_valid && oreq_ready_q;

    always_comb begin
        count_d  = count_q + CW'(push) - CW'(pop);
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
    end

    // Buffer storage and array carry no reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (push) begin
            wb_addr_q[wr_ptr_q] <= iram_addr_wdata[AW+1:2];
            wb_data_q[wr_ptr_q] <= iram_data_wdata;
        end
        if (mem_we) begin
            mem_q[wb_addr_q[rd_ptr_q]] <= wb_data_q[rd_ptr_q];
        end
    end

    always_comb begin
        state_d       = state_q;
        lat_d         = lat_q;
        line_idx_d    = line_idx_q;
        line_d        = line_q;
        oline_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fill_acc) begin
                    line_idx_d = ireq_addr[AW+1:4];
                    if ((count_q == '0) && !push) begin
                        state_d = S_READ_WAIT;
                        lat_d   = LAT_INIT;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (count_d == '0) begin
                    state_d = S_READ_WAIT;
                    lat_d   = LAT_INIT;
                end
            end
            S_READ_WAIT: begin
                // First wait cycle snapshots the line; later stores only queue.
                if (lat_q == LAT_INIT) begin
                    line_d = {mem_q[{line_idx_q, 2'd3}],
                              mem_q[{line_idx_q, 2'd2}],
                              mem_q[{line_idx_q, 2'd1}],
                              mem_q[{line_idx_q, 2'd0}]};
                end
                if (lat_q == '0) begin
                    state_d       = S_RESP;
                    oline_valid_d = 1'b1;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        oreq_ready_d = (state_d == S_IDLE);
        obusy_d      = (state_d != S_IDLE) || (count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            lat_q         <= '0;
            line_idx_q    <= '0;
            line_q        <= '0;
            oline_valid_q <= 1'b0;
            oreq_ready_q  <= 1'b1;
            obusy_q       <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            lat_q         <= lat_d;
            line_idx_q    <= line_idx_d;
            line_q        <= line_d;
            oline_valid_q <= oline_valid_d;
            oreq_ready_q  <= oreq_ready_d;
            obusy_q       <= obusy_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    assign oreq_ready  = oreq_ready_q;
    assign oline_valid = oline_valid_q;
    assign oline_data  = line_q;
    assign obusy       = obusy_q;

`ifdef MEM_STATS_EN
    logic [31:0] fill_cnt_q, fill_cnt_d;
    logic [31:0] store_cnt_q, store_cnt_d;

    always_comb begin
        fill_cnt_d  = fill_cnt_q + 32'(state_q == S_RESP);
        store_cnt_d = store_cnt_q + 32'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_cnt_q  <= '0;
            store_cnt_q <= '0;
        end else begin
            fill_cnt_q  <= fill_cnt_d;
            store_cnt_q <= store_cnt_d;
        end
    end

    assign ofill_count  = fill_cnt_q;
    assign ostore_count = store_cnt_q;
`endif

endmodule

// File: tb/tb_main_memory_responder.sv
// Bench for main_memory_responder: word model plus expected-line queue.
// Stats checks are compiled in when MEM_STATS_EN is defined.
module tb_main_memory_responder;

    logic         clk = 1'b0;
    logic         rst;
    logic         ireq_valid;
    logic [31:0]  ireq_addr;
    logic         oreq_ready;
    logic         oline_valid;
    logic [127:0] oline_data;
    logic         iwr_valid;
    logic [31:0]  iram_addr_wdata;
    logic [31:0]  iram_data_wdata;
    logic         owr_ready;
    logic         obusy;
`ifdef MEM_STATS_EN
    logic [31:0]  ofill_count;
    logic [31:0]  ostore_count;
`endif

    main_memory_responder dut (
        .clk             (clk),
        .rst             (rst),
        .ireq_valid      (ireq_valid),
        .ireq_addr       (ireq_addr),
        .oreq_ready      (oreq_ready),
        .oline_valid     (oline_valid),
        .oline_data      (oline_data),
        .iwr_valid       (iwr_valid),
        .iram_addr_wdata (iram_addr_wdata),
        .iram_data_wdata (iram_data_wdata),
        .owr_ready       (owr_ready),
`ifdef MEM_STATS_EN
        .ofill_count     (ofill_count),
        .ostore_count    (ostore_count),
`endif
        .obusy           (obusy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;
    int to_err = 0;

    logic [31:0]  mdl [0:1023];
    logic [127:0] exp_q [$];
    logic [9:0]   mb;

    // Model: stores land before a same-cycle fill snapshots its line.
    always @(negedge clk) begin
        if (!rst) begin
            if (iwr_valid && owr_ready)
                mdl[iram_addr_wdata[11:2]] = iram_data_wdata;
            if (ireq_valid && oreq_ready) begin
                mb = {ireq_addr[11:4], 2'b00};
                exp_q.push_back({mdl[mb+3], mdl[mb+2], mdl[mb+1], mdl[mb]});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                            output int waited, output int acc);
        iwr_valid = 1'b1;
        iram_addr_wdata = a;
        iram_data_wdata = d;
        waited = 0;
        acc = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (owr_ready) begin
                acc = cyc;
                break;
            end
            waited++;
        end
        if (acc < 0) to_err++;
        tick();
        iwr_valid = 1'b0;
    endtask

    task automatic do_fill(input logic [31:0] a, output int acc);
        ireq_valid = 1'b1;
        ireq_addr = a;
        acc = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (oreq_ready) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) to_err++;
        tick();
        ireq_valid = 1'b0;
    endtask

    task automatic get_line(output bit got, output logic [127:0] d, output int c);
        got = 1'b0;
        d = 'x;
        c = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (oline_valid) begin
                got = 1'b1;
                d = oline_data;
                c = cyc;
                break;
            end
        end
        if (!got) to_err++;
        tick();
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!obusy) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) to_err++;
        tick();
    endtask

    task automatic preload(input logic [31:0] base, input logic [31:0] w0,
                           input logic [31:0] w1, input logic [31:0] w2,
                           input logic [31:0] w3);
        int w, a;
        do_store(base, w0, w, a);
        do_store(base + 4, w1, w, a);
        do_store(base + 8, w2, w, a);
        do_store(base + 12, w3, w, a);
        wait_idle();
    endtask

    function automatic logic [127:0] pop_exp();
        if (exp_q.size() == 0) return 'x;
        return exp_q.pop_front();
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        ireq_valid = 1'b0;
        ireq_addr = '0;
        iwr_valid = 1'b0;
        iram_addr_wdata = '0;
        iram_data_wdata = '0;
        repeat (3) tick();
        @(negedge clk);
        n_total++;
        if (oreq_ready !== 1'b1) $display("FAIL rst_oreq_ready: got %b want 1", oreq_ready);
        else n_pass++;
        n_total++;
        if (owr_ready !== 1'b1) $display("FAIL rst_owr_ready: got %b want 1", owr_ready);
        else n_pass++;
        n_total++;
        if (oline_valid !== 1'b0) $display("FAIL rst_oline_valid: got %b want 0", oline_valid);
        else n_pass++;
        n_total++;
        if (oline_data !== 128'h0) $display("FAIL rst_oline_data: got %h want 0", oline_data);
        else n_pass++;
        n_total++;
        if (obusy !== 1'b0) $display("FAIL rst_obusy: got %b want 0", obusy);
        else n_pass++;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fill_basic();
        int t, c;
        bit got;
        logic [127:0] d, e;
        preload(32'h40, 32'h11, 32'h22, 32'h33, 32'h44);
        do_fill(32'h48, t);
        get_line(got, d, c);
        e = pop_exp();
        n_total++;
        if (got !== 1'b1) $display("FAIL basic_valid: got %b want 1", got);
        else n_pass++;
        n_total++;
        if (c !== t + 4) $display("FAIL basic_latency: got %0d want %0d", c, t + 4);
        else n_pass++;
        n_total++;
        if (d !== e) $display("FAIL basic_model: got %h want %h", d, e);
        else n_pass++;
        n_total++;
        if (d !== {32'h44, 32'h33, 32'h22, 32'h11})
            $display("FAIL basic_data: got %h want 44/33/22/11", d);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (oline_valid !== 1'b0) $display("FAIL basic_pulse: got %b want 0", oline_valid);
        else n_pass++;
        tick();
    endtask

    task automatic test_store_fill_same_cycle();
        int t, c;
        bit got, wr_ok, rq_ok;
        logic [127:0] d, e;
        wait_idle();
        iwr_valid = 1'b1;
        iram_addr_wdata = 32'h44;
        iram_data_wdata = 32'hDEAD_BEEF;
        ireq_valid = 1'b1;
        ireq_addr = 32'h40;
        @(negedge clk);
        wr_ok = owr_ready;
        rq_ok = oreq_ready;
        t = cyc;
        tick();
        iwr_valid = 1'b0;
        ireq_valid = 1'b0;
        get_line(got, d, c);
        e = pop_exp();
        n_total++;
        if ({wr_ok, rq_ok} !== 2'b11) $display("FAIL same_accept: got %b%b want 11", wr_ok, rq_ok);
        else n_pass++;
        n_total++;
        if (c !== t + 5) $display("FAIL same_latency: got %0d want %0d", c, t + 5);
        else n_pass++;
        n_total++;
        if (d !== e) $display("FAIL same_model: got %h want %h", d, e);
        else n_pass++;
        n_total++;
        if (d[63:32] !== 32'hDEAD_BEEF) $display("FAIL same_word1: got %h want deadbeef", d[63:32]);
        else n_pass++;
    endtask

    task automatic test_buffer_full();
        int t, c, t2;
        int w [5];
        int acc [5];
        bit got;
        logic [127:0] d, e;
        logic [31:0] va [5];
        logic [31:0] aa [5];
        for (int k = 0; k < 5; k++) begin
            aa[k] = 32'h100 + 32'(4 * k);
            va[k] = 32'h5A00_0000 + 32'(k + 1);
        end
        preload(32'h100, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
        preload(32'h110, 32'hB0, 32'hB1, 32'hB2, 32'hB3);
        do_fill(32'h100, t);
        fork
            get_line(got, d, c);
            begin
                for (int k = 0; k < 5; k++) do_store(aa[k], va[k], w[k], acc[k]);
            end
        join
        e = pop_exp();
        n_total++;
        if (c !== t + 4) $display("FAIL full_latency: got %0d want %0d", c, t + 4);
        else n_pass++;
        n_total++;
        if (d !== {32'hA3, 32'hA2, 32'hA1, 32'hA0} || d !== e)
            $display("FAIL full_snapshot: got %h want %h", d, e);
        else n_pass++;
        n_total++;
        if ((w[0] | w[1] | w[2] | w[3]) !== 0)
            $display("FAIL full_first4: got waits %0d %0d %0d %0d want 0", w[0], w[1], w[2], w[3]);
        else n_pass++;
        n_total++;
        if (!(w[4] > 0)) $display("FAIL full_fifth_blocked: got wait %0d want >0", w[4]);
        else n_pass++;
        n_total++;
        if (!(acc[4] > c)) $display("FAIL full_fifth_after_resp: got %0d want >%0d", acc[4], c);
        else n_pass++;
        do_fill(32'h100, t2);
        get_line(got, d, c);
        e = pop_exp();
        n_total++;
        if (d !== {va[3], va[2], va[1], va[0]} || d !== e)
            $display("FAIL full_readback0: got %h want %h", d, {va[3], va[2], va[1], va[0]});
        else n_pass++;
        do_fill(32'h110, t2);
        get_line(got, d, c);
        e = pop_exp();
        n_total++;
        if (d !== {32'hB3, 32'hB2, 32'hB1, va[4]} || d !== e)
            $display("FAIL full_readback1: got %h want %h", d, e);
        else n_pass++;
    endtask

    task automatic test_same_addr();
        int t, c, w, a;
        bit got;
        logic [127:0] d, e;
        preload(32'h80, 32'h9, 32'hC1, 32'hC2, 32'hC3);
        do_store(32'h80, 32'd1, w, a);
        do_store(32'h80, 32'd2, w, a);
        do_store(32'h80, 32'd3, w, a);
        do_fill(32'h80, t);
        get_line(got, d, c);
        e = pop_exp();
        n_total++;
        if (d[31:0] !== 32'd3) $display("FAIL order_word0: got %h want 3", d[31:0]);
        else n_pass++;
        n_total++;
        if (d !== e) $display("FAIL order_model: got %h want %h", d, e);
        else n_pass++;
    endtask

    task automatic test_reset_mid_fill();
        int t, c, pulses;
        bit got;
        logic [127:0] d, e;
        wait_idle();
        do_fill(32'h40, t);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        n_total++;
        if ({oreq_ready, obusy} !== 2'b10)
            $display("FAIL rmid_state: got ready=%b busy=%b want 1 0", oreq_ready, obusy);
        else n_pass++;
        pulses = oline_valid ? 1 : 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (oline_valid) pulses++;
        end
        n_total++;
        if (pulses !== 0) $display("FAIL rmid_no_pulse: got %0d pulses want 0", pulses);
        else n_pass++;
        tick();
        do_fill(32'h40, t);
        get_line(got, d, c);
        e = pop_exp();
        n_total++;
        if (d !== {32'h44, 32'h33, 32'hDEAD_BEEF, 32'h11} || d !== e)
            $display("FAIL rmid_array: got %h want %h", d, e);
        else n_pass++;
        n_total++;
        if (c !== t + 4) $display("FAIL rmid_latency: got %0d want %0d", c, t + 4);
        else n_pass++;
    endtask

`ifdef MEM_STATS_EN
    task automatic test_stats();
        int t, c, w, a;
        bit got;
        logic [127:0] d, e;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) do_store(32'h100 + 32'(4 * k), 32'h7700 + 32'(k), w, a);
        wait_idle();
        do_fill(32'h40, t);
        get_line(got, d, c);
        e = pop_exp();
        do_fill(32'h80, t);
        get_line(got, d, c);
        e = pop_exp();
        do_fill(32'h100, t);
        get_line(got, d, c);
        e = pop_exp();
        n_total++;
        if (d !== e) $display("FAIL stats_line: got %h want %h", d, e);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (ofill_count !== 32'd3) $display("FAIL stats_fills: got %0d want 3", ofill_count);
        else n_pass++;
        n_total++;
        if (ostore_count !== 32'd6) $display("FAIL stats_stores: got %0d want 6", ostore_count);
        else n_pass++;
        tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        n_total++;
        if ({ofill_count, ostore_count} !== 64'h0)
            $display("FAIL stats_rst: got %0d %0d want 0 0", ofill_count, ostore_count);
        else n_pass++;
        tick();
        rst = 1'b0;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_fill_basic();
        test_store_fill_same_cycle();
        test_buffer_full();
        test_same_addr();
        test_reset_mid_fill();
`ifdef MEM_STATS_EN
        test_stats();
`endif
        n_total++;
        if (to_err !== 0) $display("FAIL timeouts: got %0d want 0", to_err);
        else n_pass++;
        n_total++;
        if (exp_q.size() !== 0) $display("FAIL leftover_lines: got %0d want 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
